// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter through the Tx_DATA/Tx_WR/Tx_BUSY handshake.
// Optional almost_full output is enabled by defining UART_TX_FIFO_ALMOST_FULL_EN.
module uart_tx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned BUSY_WAIT = 16
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
  ,
  parameter int unsigned AF_LEVEL  = DEPTH - 2
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  input  logic            drain_en,
  input  logic            ovf_clr,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow,
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
  output logic            almost_full,
`endif
  output logic [7:0]      Tx_DATA,
  output logic            Tx_WR,
  input  logic            Tx_BUSY
);

  localparam int unsigned CntW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BUSY_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWaitHi, StWaitLo} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_wr_q, tx_wr_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic              push, pop;

  always_comb begin
    state_d    = state_q;
    tx_wr_d    = 1'b0;
    tx_data_d  = tx_data_q;
    wait_cnt_d = wait_cnt_q;
    pop        = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty_q && drain_en && !Tx_BUSY) begin
          state_d   = StLoad;
          pop       = 1'b1;
          tx_wr_d   = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
        end
      end
      StLoad: begin
        state_d    = StWaitHi;
        wait_cnt_d = '0;
      end
      StWaitHi: begin
        if (Tx_BUSY) begin
          state_d = StWaitLo;
        end else if (drain_en) begin
          // Transmitter missed the strobe: re-pulse the byte already in Tx_DATA.
          if (wait_cnt_q == CntMax) begin
            state_d = StLoad;
            tx_wr_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      StWaitLo: begin
        if (!Tx_BUSY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A pop in the same edge frees a slot, so a push to a full FIFO is accepted then.
  always_comb begin
    push       = wr_en && (!full_q || pop);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d     = (count_d == (ADDR_W + 1)'(DEPTH));
    empty_d    = (count_d == '0);
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (wr_en && !push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_wr_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_wr_q    <= tx_wr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef UART_TX_FIFO_ALMOST_FULL_EN
  logic almost_full_q, almost_full_d;

  always_comb begin
    almost_full_d = (32'(count_d) >= AF_LEVEL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) almost_full_q <= 1'b0;
    else       almost_full_q <= almost_full_d;
  end

  assign almost_full = almost_full_q;
`endif

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign Tx_DATA  = tx_data_q;
  assign Tx_WR    = tx_wr_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer directly upstream of uart_transmitter.
- Accepts bytes from the host side in single-cycle writes and stores them in a circular FIFO.
- Drains them one at a time into the transmitter's Tx_DATA/Tx_WR/Tx_BUSY handshake.
- Lets software queue a burst without polling Tx_BUSY per byte.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two.
- ADDR_W, 4, pointer width; equals log2(DEPTH).
- BUSY_WAIT, 16, max cycles to wait for Tx_BUSY to rise after a Tx_WR pulse before re-issuing the pulse.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  push wr_data this cycle.
- wr_data  input  8  byte to queue.
- drain_en  input  1  permits launching new bytes to the transmitter; tie to Tx_EN.
- ovf_clr  input  1  clears the overflow flag.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  stored entries, excluding the byte held in Tx_DATA.
- overflow  output  1  sticky; a push was dropped.
- Tx_DATA  output  8  byte presented to the transmitter.
- Tx_WR  output  1  one-cycle launch strobe to the transmitter.
- Tx_BUSY  input  1  transmitter busy flag.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-high.
  - All state clears immediately on reset assertion.
- Reset values:
  - full=0, empty=1, count=0, overflow=0, Tx_DATA=8'h00, Tx_WR=0.
  - Pointers 0, FSM in IDLE.
  - Storage contents are don't-care.
- Reset mid-operation: any queued or in-flight byte is discarded. The transmitter is not aborted by this block.
- Push:
  - On an edge with wr_en=1 and full=0: mem[wr_ptr]<=wr_data, wr_ptr wraps modulo DEPTH, count+1.
  - wr_en=1 with full=1: data dropped, overflow<=1, pointers and count unchanged.
- Overflow flag: ovf_clr=1 clears it. If ovf_clr and an overflowing push occur in the same cycle, set wins.
- Pop: happens only on the IDLE->LOAD transition. Tx_DATA<=mem[rd_ptr], rd_ptr wraps, count-1.
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - Legal even when full, because the pop frees the slot in the same edge.
  - Push into an empty FIFO with a same-cycle pop is impossible: pop requires count!=0 at the sampling edge.
- full/empty/count are registered and consistent with each other every cycle.
- FSM states:
  - IDLE: when count!=0, drain_en=1 and Tx_BUSY=0, go to LOAD; pop and set Tx_WR<=1.
  - LOAD: Tx_WR is high for exactly this one cycle. Next state is WAIT_HI; Tx_WR<=0; the wait counter clears.
  - WAIT_HI: on Tx_BUSY=1, go to WAIT_LO. If the counter reaches BUSY_WAIT-1 without Tx_BUSY, go back to LOAD and re-pulse the same Tx_DATA (no new pop). Retries are unlimited but only while drain_en=1; if drain_en=0, stay in WAIT_HI and hold the counter.
  - WAIT_LO: on Tx_BUSY=0, go to IDLE.
- Tx_DATA holds stable from LOAD until the next pop.
- Latency: a byte written into an empty FIFO at edge N with transmitter idle gives empty=0 after N, the pop at N+1, and Tx_WR high during cycle N+1..N+2.
- Back-to-back bytes: the minimum gap is one IDLE cycle after Tx_BUSY falls.
- drain_en=0 blocks only new launches; an in-flight byte completes its handshake.

Optional Feature:
- Macro: UART_TX_FIFO_ALMOST_FULL_EN.
- When defined:
  - Adds parameter AF_LEVEL (default DEPTH-2) and output almost_full (1 bit).
  - almost_full is registered, =1 when count>=AF_LEVEL, reset 0, and updated on the same edge as count.
- When undefined: the port and parameter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset released, no writes -> empty=1, count=0, Tx_WR never asserts, Tx_DATA=8'h00.
- Write 8'h99, transmitter model asserts Tx_BUSY 1 cycle after Tx_WR and holds it 160 cycles -> single Tx_WR pulse carrying 8'h99 at cycle N+1; FSM returns to IDLE; empty=1.
- Write 8'hAA, 8'hAD, 8'h55 on consecutive cycles -> count peaks at 2 or 3. Transmitter sees AA, AD, 55 in order, exactly one Tx_WR per byte, each launched only after Tx_BUSY has fallen.
- drain_en=0, write 17 bytes 8'h00..8'h10 -> full=1 after 16 bytes, the 17th is dropped, overflow=1. Then pulse ovf_clr -> overflow=0. Then set drain_en=1 -> bytes 00..0F are transmitted in order.
- Transmitter model ignores the first Tx_WR (Tx_BUSY stays 0) -> Tx_WR re-pulses after BUSY_WAIT=16 cycles with the same Tx_DATA and count unchanged. Transmitter then accepts and the sequence completes.
- Assert reset in WAIT_LO with 3 bytes queued -> outputs immediately return to reset values, count=0, and no further Tx_WR after reset release.
